// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES-128/256 block decipher, one inverse round per clock.
// aes_inv_sbox derives the inverse S-box as GF(2^8) inversion of the inverse affine transform.
module aes_inv_sbox (
  input  logic [7:0] val,
  output logic [7:0] sub
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] a, x2, x3, x12, x15, x240;
  assign a    = {val[6:0], val[7]} ^ {val[4:0], val[7:5]} ^ {val[1:0], val[7:2]} ^ 8'h05;
  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x12  = gmul(gmul(x3, x3), gmul(x3, x3));
  assign x15  = gmul(x12, x3);
  assign x240 = gmul(gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))),
                     gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))));
  // a^254 is the multiplicative inverse, with 0 mapping to 0
  assign sub  = gmul(gmul(x240, x12), x2);
endmodule

module aes_decipher_block (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  input  logic [127:0] round_key,
  output logic [3:0]   round,
  output logic [127:0] new_block,
  output logic         ready
);
  typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} fsm_t;
  fsm_t fsm, fsm_nxt;
  logic [127:0] st, isr, sb, ark, imc;
  logic [3:0]   cnt;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] inv_mix(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
  // row r rotates right by r: output column c takes input column c-r
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
      aes_inv_sbox u_sbox (.val(isr[127-8*(4*c+r) -: 8]), .sub(sb[127-8*(4*c+r) -: 8]));
    end
    assign imc[127-32*c -: 32] = inv_mix(ark[127-32*c -: 32]);
  end
  assign ark   = sb ^ round_key;
  assign round = cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) fsm <= IDLE;
    else fsm <= fsm_nxt;
  always_comb
    fsm_nxt = fsm == IDLE ? (next ? INIT : IDLE) :
              fsm == INIT ? MAIN :
              fsm == MAIN ? (cnt == 4'd1 ? FINAL : MAIN) : IDLE;
  always_comb
    ready = fsm == IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st        <= '0;
      cnt       <= '0;
      new_block <= '0;
    end else if (fsm == IDLE && next) begin
      st  <= block;
      cnt <= keylen ? 4'd14 : 4'd10;
    end else if (fsm == INIT) begin
      st  <= st ^ round_key;
      cnt <= cnt - 4'd1;
    end else if (fsm == MAIN) begin
      st  <= imc;
      cnt <= cnt - 4'd1;
    end else if (fsm == FINAL) begin
      st        <= ark;
      new_block <= ark;
    end
endmodule

// File: tb/tb_aes_decipher_block.sv
// tb_aes_decipher_block: FIPS-197 known-answer runs with a result scoreboard and a behavioural key memory.
module tb_aes_decipher_block;
  logic         clk = 1'b0;
  logic         reset_n, next, keylen;
  logic [127:0] block, round_key, new_block;
  logic [3:0]   round;
  logic         ready;
  logic [127:0] rk128 [0:15];
  logic [127:0] rk256 [0:15];
  logic         cur_kl;
  logic [127:0] sb_q [$];
  logic [127:0] last_res;
  int           passed = 0, total = 0;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  aes_decipher_block dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .block(block),
    .round_key(round_key), .round(round), .new_block(new_block), .ready(ready)
  );

  always #5 clk = ~clk;
  assign round_key = cur_kl ? rk256[round] : rk128[round];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 254; i++) p = gm(p, x);
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input bit sel);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      if (sel) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // caller sits at a negedge; returns at the first negedge that sees ready=1
  task automatic run_op(input logic kl, input logic [127:0] blk, input logic [127:0] exp,
                        input int nr, input bit poke);
    int k;
    cur_kl = kl;
    keylen = kl;
    block  = blk;
    next   = 1'b1;
    sb_q.push_back(exp);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        next = 1'b0;
        chk("hold_while_busy", new_block, last_res);
      end
      if (poke && k == 5) begin
        next   = 1'b1;
        keylen = ~kl;
        block  = '1;
      end
      if (poke && k == 6) next = 1'b0;
      if (ready) break;
      chk("round", 128'(round), 128'(nr - k));
    end
    chk("latency", 128'(k), 128'(nr + 1));
    if (sb_q.size() == 0) begin
      total++;
      $error("FAIL scoreboard: result with nothing expected, got %h", new_block);
    end else chk("result", new_block, sb_q.pop_front());
    last_res = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 1'b0);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b1);
    reset_n  = 1'b0;
    next     = 1'b0;
    keylen   = 1'b0;
    block    = '0;
    cur_kl   = 1'b0;
    last_res = '0;
    #1;
    chk("reset_ready", 128'(ready), 128'(1));
    chk("reset_new_block", new_block, '0);
    chk("reset_round", 128'(round), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // C.1 with next/keylen/block disturbed mid-operation
    run_op(1'b0, C1, PT, 10, 1'b1);
    // result hold with block toggling and next low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      block = {$urandom, $urandom, $urandom, $urandom};
      chk("hold_result", new_block, PT);
      chk("hold_ready", 128'(ready), 128'(1));
    end
    // back-to-back: C.3 starts in the first ready cycle after C.1
    run_op(1'b0, C1, PT, 10, 1'b0);
    run_op(1'b1, C3, PT, 14, 1'b0);
    // reset in the middle of a C.1 run
    cur_kl = 1'b0;
    keylen = 1'b0;
    block  = C1;
    next   = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_new_block", new_block, '0);
    chk("abort_round", 128'(round), '0);
    @(negedge clk);
    reset_n  = 1'b1;
    last_res = '0;
    @(negedge clk);
    run_op(1'b0, C1, PT, 10, 1'b0);
    chk("scoreboard_drained", 128'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes_decipher_block.md
# aes_decipher_block

Iterative AES block decipher: inverts one 128-bit ciphertext block per request, performing one inverse round per clock cycle. It sits beside the encipher datapath in the core and shares the same external round-key memory, which supplies the round key for the `round` index this block presents. It supports AES-128 (10 rounds) and AES-256 (14 rounds), selected per block.

## Interface

Parameters:
- none; the round count is selected at run time by `keylen`.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `next` in 1: start pulse. Sampled only while `ready`=1.
- `keylen` in 1: key length select, 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14). Sampled together with `next`.
- `block` in 128: ciphertext. Sampled together with `next`.
- `round_key` in 128: round key for index `round`. Driven combinationally by the key memory in the same cycle.
- `round` out 4: index of the round key requested. Driven directly from the round counter register.
- `new_block` out 128: plaintext result. Valid while `ready`=1 after a completed operation.
- `ready` out 1: 1 = idle and result valid, 0 = busy.

## Operation

- Byte order follows FIPS-197, column-major: `block[127:120]` is s(0,0), `[119:112]` is s(1,0), …, `[7:0]` is s(3,3). The same order applies to `round_key` and `new_block`.
- The FSM has four states: IDLE, INIT, MAIN, FINAL.
- **IDLE**, when `next`=1:
  - latch `block` into the state register;
  - latch Nr from `keylen`;
  - load round counter = Nr;
  - `ready` <= 0;
  - go to INIT.
- **INIT**:
  - state <= state ^ `round_key` (key Nr);
  - counter <= Nr-1;
  - go to MAIN.
- **MAIN**:
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), `round_key`));
  - counter decrements each cycle;
  - when the counter is 1, the next state is FINAL and counter <= 0.
- **FINAL**:
  - state <= InvSubBytes(InvShiftRows(state)) ^ `round_key` (key 0);
  - `new_block` <= that value;
  - `ready` <= 1;
  - go to IDLE.
- InvShiftRows rotates row r right by r byte positions.
- InvSubBytes uses 16 instances of the existing `aes_inv_sbox` module.
- InvMixColumns works in GF(2^8) with the reduction polynomial 0x11b. It uses coefficients 0e/0b/0d/09, built from chained xtime (gmul2) operations. Every product is 8 bits; there is no carry.
- `next` while busy is ignored. It is not queued and has no effect on the state.
- `keylen` and `block` changes while busy are ignored.
- `new_block` holds its value until the next FINAL cycle overwrites it. A new start does not clear it.

## Timing

- Reset values, applied asynchronously and immediately:
  - `ready`=1;
  - `new_block`=0;
  - `round`=0;
  - FSM=IDLE;
  - internal state register=0.
- Reset mid-operation aborts the block. The outputs return to the reset values and no partial result appears.
- Let edge E0 be the edge at which `next` is accepted. Then:
  - `ready` falls after E0;
  - INIT executes at E1 with `round`=Nr;
  - MAIN rounds execute at E2..E(Nr) with `round`=Nr-1..1;
  - FINAL executes at E(Nr+1) with `round`=0;
  - `ready` and `new_block` update after E(Nr+1).
- Latency from the `next` edge to `ready` high is Nr+1 cycles: 11 for AES-128, 15 for AES-256.
- `round` changes only on clock edges. The key memory has a full cycle to settle `round_key`.
- Back-to-back operation: `next` may be asserted in the first cycle that `ready`=1. Throughput is therefore one block per Nr+2 cycles.
- If `next` is asserted in the same cycle as FINAL, it is ignored, because `ready` is still 0.

## Test plan

- **AES-128 FIPS-197 C.1.**
  - Stimulus: the bench key table is the expanded key of 000102030405060708090a0b0c0d0e0f; `keylen`=0; `block`=69c4e0d86a7b0430d8cdb78070b4c55a; pulse `next`.
  - Required response: `ready` rises exactly 11 cycles later with `new_block`=00112233445566778899aabbccddeeff; `round` steps 10,9,…,0.
- **AES-256 FIPS-197 C.3.**
  - Stimulus: the key table is the expansion of 00..1f; `keylen`=1; `block`=8ea2b7ca516745bfeafc49904b496089.
  - Required response: after 15 cycles `new_block`=00112233445566778899aabbccddeeff.
- **Busy-time inputs ignored.**
  - Stimulus: during the C.1 run, pulse `next` at cycle 5, flip `keylen` to 1, and change `block` to all-ones.
  - Required response: the result and the 11-cycle latency are unchanged, and no second operation starts.
- **Back-to-back operation.**
  - Stimulus: assert `next` in the first `ready`=1 cycle after C.1, with the C.3 inputs.
  - Required response: the C.1 result is visible for exactly one cycle with `ready`=1, then the C.3 result arrives 15 cycles later.
- **Reset mid-operation.**
  - Stimulus: assert `reset_n`=0 at cycle 6 of C.1.
  - Required response: `ready`=1, `new_block`=0 and `round`=0 immediately, before any clock edge. A fresh C.1 run afterwards gives the correct result.
- **Result hold.**
  - Stimulus: after C.1 completes, leave `next` low for 20 cycles while toggling `block`.
  - Required response: `new_block` stays 00112233445566778899aabbccddeeff and `ready` stays 1.
